// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : RV32I constants and the IF/ID register record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/if_id_fetch_stage_pc_reg.sv
// ============================================================================
// Module : if_id_fetch_stage_pc_reg
// Brief  : Program counter with hold / +4 / word-aligned redirect selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_fetch_stage_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Hold wins over redirect so a stalled branch is never resolved early.
  always_comb begin
    pc_d = pc_q;
    if (hold_i) begin
      pc_d = pc_q;
    end else if (redirect_i) begin
      pc_d = {target_i[31:2], 2'b00};
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// Module : if_id_fetch_stage
// Brief  : RV32I fetch stage, IF/ID pipeline register and fetch/bubble counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_fetch_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o,
  output logic [XLEN-1:0] fetch_cnt_o,
  output logic [XLEN-1:0] bubble_cnt_o
);

  logic        pc_hold;
  logic [31:0] pc;

  if_id_t      if_id_q;
  if_id_t      if_id_d;
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  assign pc_hold = !start_i || stall_i;

  if_id_fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .hold_i     (pc_hold),
    .redirect_i (flush_i),
    .target_i   (branch_target_i),
    .pc_o       (pc)
  );

  // Priority: idle bubble, then stall hold, then flush bubble, then fetch.
  always_comb begin
    if_id_d      = if_id_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!start_i) begin
      if_id_d      = '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (flush_i) begin
      if_id_d      = '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      if_id_d     = '{pc: pc, instr: imem_data_i, valid: 1'b1};
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_id_q      <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if_id_q      <= if_id_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign imem_addr_o  = pc;
  assign pc_o         = if_id_q.pc;
  assign instr_o      = if_id_q.instr;
  assign valid_o      = if_id_q.valid;
  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
// ============================================================================
// Module : tb_if_id_fetch_stage
// Brief  : Directed scoreboard bench for the fetch stage and IF/ID register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  if_id_fetch_stage dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o),
    .fetch_cnt_o     (fetch_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o)
  );

  // Instruction memory contents: fixed word at 0, address-derived elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0050_0093 : ((a ^ 32'h1357_9000) | 32'h0000_0013);
  endfunction

  assign imem_data_i = mem(imem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle's inputs (caller sits at a negedge) and queue the result.
  task automatic step(input logic st, input logic sl, input logic fl, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic e_valid, input logic [31:0] e_addr,
                      input logic [31:0] e_fc, input logic [31:0] e_bc);
    exp_t e;
    start_i = st;
    stall_i = sl;
    flush_i = fl;
    branch_target_i = tgt;
    if (st && sl && fl) $display("WARNING: stall and flush asserted together at %0t", $time);
    e.pc    = e_pc;
    e.instr = e_valid ? mem(e_pc) : NOP;
    e.valid = e_valid;
    e.addr  = e_addr;
    e.fc    = e_fc;
    e.bc    = e_bc;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},    pc_o, 32'd0);
    check({tag, "_instr"}, instr_o, NOP);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_addr"},  imem_addr_o, 32'd0);
    check({tag, "_fcnt"},  fetch_cnt_o, 32'd0);
    check({tag, "_bcnt"},  bubble_cnt_o, 32'd0);
  endtask

  // Monitor: one registered result per clock while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("instr_o", instr_o, e.instr);
        check("valid_o", {31'd0, valid_o}, {31'd0, e.valid});
        check("imem_addr_o", imem_addr_o, e.addr);
        check("fetch_cnt_o", fetch_cnt_o, e.fc);
        check("bubble_cnt_o", bubble_cnt_o, e.bc);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_i = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    branch_target_i = 32'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_i = 1'b1;

    //    st sl fl target         pc_o           v  imem_addr      fc  bc
    step(1, 0, 0, 32'h0,          32'h0,         1, 32'h4,         1,  0);
    step(1, 0, 0, 32'h0,          32'h4,         1, 32'h8,         2,  0);
    step(1, 0, 0, 32'h0,          32'h8,         1, 32'hC,         3,  0);
    step(1, 1, 0, 32'h0,          32'h8,         1, 32'hC,         3,  0);
    step(1, 1, 0, 32'h0,          32'h8,         1, 32'hC,         3,  0);
    step(1, 1, 0, 32'h0,          32'h8,         1, 32'hC,         3,  0);
    step(1, 0, 0, 32'h0,          32'hC,         1, 32'h10,        4,  0);
    step(1, 0, 1, 32'h40,         32'h0,         0, 32'h40,        4,  1);
    step(1, 0, 0, 32'h0,          32'h40,        1, 32'h44,        5,  1);
    step(1, 1, 1, 32'h80,         32'h40,        1, 32'h44,        5,  1);
    step(1, 0, 1, 32'h80,         32'h0,         0, 32'h80,        5,  2);
    step(1, 0, 0, 32'h0,          32'h80,        1, 32'h84,        6,  2);
    step(1, 0, 1, 32'hFFFF_FFFC,  32'h0,         0, 32'hFFFF_FFFC, 6,  3);
    step(1, 0, 0, 32'h0,          32'hFFFF_FFFC, 1, 32'h0,         7,  3);
    step(1, 0, 1, 32'h43,         32'h0,         0, 32'h40,        7,  4);
    step(0, 0, 0, 32'h0,          32'h0,         0, 32'h40,        7,  5);
    step(0, 1, 1, 32'h100,        32'h0,         0, 32'h40,        7,  6);
    step(1, 0, 0, 32'h0,          32'h40,        1, 32'h44,        8,  6);
    step(1, 0, 1, 32'h20,         32'h0,         0, 32'h20,        8,  7);
    step(1, 0, 0, 32'h0,          32'h20,        1, 32'h24,        9,  7);

    // Asynchronous reset between edges with PC at 0x24.
    #1;
    rst_i = 1'b0;
    start_i = 1'b1;
    #2;
    check_reset("async_rst");
    @(negedge clk);
    check_reset("rst_held");
    rst_i = 1'b1;
    step(1, 0, 0, 32'h0,          32'h0,         1, 32'h4,         1,  0);
    step(1, 0, 0, 32'h0,          32'h4,         1, 32'h8,         2,  0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
